// File: rtl/vga_timing_param.sv
// Parametrised raster timing generator: pixel/line counters, blanking, sync
// with programmable polarity, data-enable and line/frame start strobes.
module vga_timing_param #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CNT_W    = 11
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             pclk_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W)) ||
        (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
        (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) ||
        (CNT_W < 1)) begin : g_param_check
      $fatal(1, "vga_timing_param: illegal timing parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_BLNK = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hblnk;
  logic             r_vblnk;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_hcount_nxt;
  logic [CNT_W-1:0] w_vcount_nxt;

  always_comb begin
    w_h_wrap     = (r_hcount == H_LAST);
    w_v_wrap     = (r_vcount == V_LAST);
    w_hcount_nxt = w_h_wrap ? '0 : r_hcount + 1'b1;
    w_vcount_nxt = r_vcount;
    if (w_h_wrap) begin
      w_vcount_nxt = w_v_wrap ? '0 : r_vcount + 1'b1;
    end
  end

  // Flags are derived from the next counter values so they line up with the
  // counters presented in the same cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pclk_en) begin
        r_hcount      <= w_hcount_nxt;
        r_vcount      <= w_vcount_nxt;
        r_hblnk       <= (w_hcount_nxt >= H_BLNK);
        r_vblnk       <= (w_vcount_nxt >= V_BLNK);
        r_hsync       <= ((w_hcount_nxt >= H_SS) && (w_hcount_nxt < H_SE)) ? H_POL : ~H_POL;
        r_vsync       <= ((w_vcount_nxt >= V_SS) && (w_vcount_nxt < V_SE)) ? V_POL : ~V_POL;
        r_de          <= (w_hcount_nxt < H_BLNK) && (w_vcount_nxt < V_BLNK);
        r_line_start  <= w_h_wrap;
        r_frame_start <= w_h_wrap && w_v_wrap;
      end
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: three instances (tiny positive-polarity, tiny
// negative-polarity, default 1650x750) checked against a position model.
module tb_vga_timing_param;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } obs_t;

  localparam int W = $bits(obs_t);

  typedef struct {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    bit          en;
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        hs;
    logic        ls;
    logic        fs;
  } tvec_t;

  // clock / reset
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic pclk_en = 1'b0;
  always #5 pclk = ~pclk;

  logic [10:0] s_h, s_v, n_h, n_v, d_h, d_v;
  logic s_hb, s_vb, s_hs, s_vs, s_de, s_ls, s_fs;
  logic n_hb, n_vb, n_hs, n_vs, n_de, n_ls, n_fs;
  logic d_hb, d_vb, d_hs, d_vs, d_de, d_ls, d_fs;
  obs_t obs_s, obs_n, obs_d;

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(11)
  ) u_small (
    .pclk(pclk), .rst(rst), .pclk_en(pclk_en),
    .hcount(s_h), .vcount(s_v), .hblnk(s_hb), .vblnk(s_vb),
    .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_param #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(11)
  ) u_neg (
    .pclk(pclk), .rst(rst), .pclk_en(pclk_en),
    .hcount(n_h), .vcount(n_v), .hblnk(n_hb), .vblnk(n_vb),
    .hsync(n_hs), .vsync(n_vs), .de(n_de),
    .line_start(n_ls), .frame_start(n_fs)
  );

  vga_timing_param u_def (
    .pclk(pclk), .rst(rst), .pclk_en(pclk_en),
    .hcount(d_h), .vcount(d_v), .hblnk(d_hb), .vblnk(d_vb),
    .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
  );

  assign obs_s = {s_h, s_v, s_hb, s_vb, s_hs, s_vs, s_de, s_ls, s_fs};
  assign obs_n = {n_h, n_v, n_hb, n_vb, n_hs, n_vs, n_de, n_ls, n_fs};
  assign obs_d = {d_h, d_v, d_hb, d_vb, d_hs, d_vs, d_de, d_ls, d_fs};

  cfg_t cfg_s = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
  cfg_t cfg_n = '{6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
  cfg_t cfg_d = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;
  int n_adv = 0;
  int cyc = 0;
  int last_ls = -1;
  int exp_period = 0;
  logic [W-1:0] exp_q[$];

  // Position model: after n enabled advances from reset the raster sits at
  // pixel n mod H_TOTAL of line (n div H_TOTAL) mod V_TOTAL.
  function automatic obs_t model(cfg_t c, int n, bit adv);
    obs_t o;
    int ht;
    int vt;
    int x;
    int y;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    x = n % ht;
    y = (n / ht) % vt;
    o.h  = 11'(x);
    o.v  = 11'(y);
    o.hb = (x >= c.ha);
    o.vb = (y >= c.va);
    o.hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.hp : !c.hp;
    o.vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.vp : !c.vp;
    o.de = !o.hb && !o.vb;
    o.ls = adv && (x == 0);
    o.fs = adv && (x == 0) && (y == 0);
    return o;
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic check_all(input bit adv);
    exp_q.push_back(model(cfg_s, n_adv, adv));
    exp_q.push_back(model(cfg_n, n_adv, adv));
    exp_q.push_back(model(cfg_d, n_adv, adv));
    check_vec("small", obs_s, exp_q.pop_front());
    check_vec("neg", obs_n, exp_q.pop_front());
    check_vec("default", obs_d, exp_q.pop_front());
  endtask

  // driver: present en, take one edge, then check every instance
  task automatic tick(input bit en);
    pclk_en = en;
    @(posedge pclk);
    #1;
    cyc++;
    if (en) n_adv++;
    check_all(en);
    if (d_ls) begin
      if (last_ls >= 0 && exp_period > 0) check_int("ls_period", cyc - last_ls, exp_period);
      last_ls = cyc;
    end
  endtask

  tvec_t tv[20];
  obs_t corner;
  bit found;

  initial begin
    tv[0]  = '{1'b1, 11'd1,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 11'd1,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 11'd2,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 11'd3,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 11'd4,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 11'd5,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 11'd6,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 11'd7,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 11'd8,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 11'd9,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b1, 11'd10, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 11'd10, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b1, 11'd11, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b1, 11'd12, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[14] = '{1'b1, 11'd13, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[15] = '{1'b1, 11'd14, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[16] = '{1'b0, 11'd14, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[17] = '{1'b1, 11'd0,  11'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[18] = '{1'b0, 11'd0,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[19] = '{1'b1, 11'd1,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset held across several edges with enable high
    rst = 1'b1;
    pclk_en = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_all(1'b0);
    check_vec("reset_const_neg", obs_n, {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    n_adv = 0;

    // table vectors on the small instance
    for (int i = 0; i < 20; i++) begin
      tick(tv[i].en);
      check_vec("table", {s_h, s_v, s_hb, s_hs, s_ls, s_fs},
                {tv[i].h, tv[i].v, tv[i].hb, tv[i].hs, tv[i].ls, tv[i].fs});
    end

    // continuous enable: default line_start period 1650 cycles
    last_ls = -1;
    exp_period = 1650;
    for (int i = 0; i < 3400; i++) tick(1'b1);

    // divide-by-2 enable: line_start period doubles
    last_ls = -1;
    exp_period = 3300;
    for (int i = 0; i < 7000; i++) tick(i[0] == 1'b0);
    exp_period = 0;

    // frame wrap corner on the small instance
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (s_h == 11'd14 && s_v == 11'd7) found = 1'b1;
      else tick(1'b1);
    end
    check_int("corner_reached", int'(found), 1);
    tick(1'b1);
    corner = '{h: 11'd0, v: 11'd0, hb: 1'b0, vb: 1'b0, hs: 1'b0, vs: 1'b0,
               de: 1'b1, ls: 1'b1, fs: 1'b1};
    check_vec("corner_wrap", obs_s, corner);

    // random enable pattern
    for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 1)));

    // asynchronous reset pulse between edges, mid-line
    for (int i = 0; i < 5; i++) tick(1'b1);
    #3 rst = 1'b1;
    #1;
    n_adv = 0;
    check_all(1'b0);
    #1 rst = 1'b0;
    tick(1'b1);
    check_int("first_after_reset", int'(s_h), 1);
    for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Parametrised successor to the fixed-mode video timing generator.
- Generates hcount/vcount, blanking, sync with programmable polarity, a data-enable, and single-cycle line/frame-start strobes.
- A pixel clock-enable input lets a single fast pclk drive slower modes.
- Sits between the clock/reset infrastructure and the draw pipeline; its outputs feed background, rect and sprite stages, plus the VGA output register.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = positive, 0 = negative)
- V_POL, 1, vsync active level
- CNT_W, 11, width of hcount/vcount

Ports:
- pclk  input  1  pixel/system clock
- rst  input  1  asynchronous, active-high reset
- pclk_en  input  1  advance strobe; counters move only on cycles with pclk_en=1
- hcount  output  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  output  CNT_W  current line, 0..V_TOTAL-1
- hblnk  output  1  high when hcount >= H_ACTIVE
- vblnk  output  1  high when vcount >= V_ACTIVE
- hsync  output  1  H_POL when hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~H_POL
- vsync  output  1  V_POL when vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~V_POL
- de  output  1  ~hblnk & ~vblnk
- line_start  output  1  one-cycle strobe, hcount just became 0
- frame_start  output  1  one-cycle strobe, (hcount,vcount) just became (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 750).
- Elaboration check: H_TOTAL and V_TOTAL must be <= 2^CNT_W; every parameter except H_POL/V_POL must be >= 1. A violation is a fatal elaboration error.
- All outputs are registered on posedge pclk.
- All flags are mutually consistent with the hcount/vcount values presented in the same cycle. Flags are computed from the next-state counter values, not with one cycle of lag.
- Reset (async assert, sync use on release):
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0, de=1
  - hsync=~H_POL, vsync=~V_POL
  - line_start=0, frame_start=0
- Cycle with pclk_en=1:
  - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1
  - vcount increments only on the hcount wrap. It wraps to 0 when the old vcount==V_TOTAL-1.
- Cycle with pclk_en=0:
  - Counters and all level outputs hold.
  - line_start and frame_start are forced to 0. Strobes are never stretched.
- line_start=1 for exactly the one advancing cycle in which hcount wraps to 0.
- frame_start=1 only when the hcount and vcount wraps coincide. line_start is also 1 in that cycle.
- Reset release does not generate a start strobe. The first frame_start occurs after a full H_TOTAL*V_TOTAL enabled advances.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). Counting restarts from (0,0) on the first enabled edge after release, so the first advance produces hcount=1.
- Sync windows lie inside the blank windows by construction. hsync is not qualified by vblnk.
- Steady state, pclk_en tied 1: one frame = 1,237,500 cycles at defaults.

Test Plan:
- Defaults, pclk_en=1, run 2 frames from reset:
  - hblnk rises at hcount=1280, falls at 0.
  - hsync (high) spans hcount 1390..1429, exactly 40 cycles.
  - vsync spans vcount 725..729.
  - frame_start period 1,237,500 cycles.
- H_POL=0, V_POL=0, 640x480 (16/96/48, 10/2/33):
  - hsync low only for hcount 656..751; idle high.
  - vsync low only for vcount 490..491.
  - H_TOTAL=800, V_TOTAL=525.
- pclk_en toggling 1,0 (divide-by-2):
  - Counters advance every 2nd cycle.
  - line_start pulses are exactly 1 cycle wide, with period 3300 cycles.
  - No output changes on en=0 cycles.
- Wrap corner at (1649,749) with en=1:
  - Next cycle shows (0,0), de=1, vblnk=0.
  - line_start=1 and frame_start=1 in the same cycle.
- Async rst pulsed at hcount=500, vcount=300 (mid-line, between edges):
  - All outputs reach reset values before the next edge.
  - After release, the first enabled edge yields hcount=1.
  - No strobe until line end.
- de consistency check across a full frame: assert de == (hcount<1280 && vcount<720) on every cycle.
